// File: rtl/aes_block_stream_buffer.sv
// Single-buffer data mover between the input streamer and the AES core: gathers a block from
// stream beats, hands it to the core, captures the result in place and drains it back out.
module aes_block_stream_buffer #(
    parameter int DATA_W  = 32,
    parameter int BLOCK_W = 128,
    parameter int CNT_W   = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                start_i,
    input  logic [CNT_W-1:0]    nblocks_i,
    input  logic                swap_i,
    input  logic [DATA_W-1:0]   a_data_i,
    input  logic                a_valid_i,
    output logic                a_ready_o,
    output logic [BLOCK_W-1:0]  blk_o,
    output logic                blk_valid_o,
    input  logic                blk_ready_i,
    input  logic [BLOCK_W-1:0]  res_i,
    input  logic                res_valid_i,
    output logic                res_ready_o,
    output logic [DATA_W-1:0]   d_data_o,
    output logic                d_valid_o,
    input  logic                d_ready_i,
    output logic [DATA_W/8-1:0] d_strb_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [CNT_W-1:0]    blocks_done_o,
    output logic [2:0]          state_o
);

    localparam int BEATS  = BLOCK_W / DATA_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int NBYTES = DATA_W / 8;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GATHER = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q;
    logic [BLOCK_W-1:0]  buf_q;
    logic [CNT_W-1:0]    nblocks_q;
    logic [CNT_W-1:0]    blocks_done_q;
    logic                swap_q;
    logic                done_q;
    logic                last_beat;
    logic                last_block;
    logic [DATA_W-1:0]   in_word;
    logic [DATA_W-1:0]   out_word;

    function automatic logic [DATA_W-1:0] bswap(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < NBYTES; i++) begin
            r[i*8 +: 8] = d[(NBYTES-1-i)*8 +: 8];
        end
        return r;
    endfunction

    assign last_beat  = (beat_q == LAST_BEAT);
    assign last_block = ((blocks_done_q + CNT_W'(1)) == nblocks_q);
    assign in_word    = swap_q ? bswap(a_data_i) : a_data_i;

    always_comb begin
        out_word = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (beat_q == BEAT_W'(i)) out_word = buf_q[i*DATA_W +: DATA_W];
        end
    end

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // Every ready/valid driven here decodes state_q only, so no valid reaches a ready combinationally.
    assign a_ready_o     = (state_q == ST_GATHER);
    assign blk_valid_o   = (state_q == ST_ISSUE);
    assign res_ready_o   = (state_q == ST_WAIT);
    assign d_valid_o     = (state_q == ST_DRAIN);
    assign blk_o         = buf_q;
    assign d_data_o      = d_valid_o ? (swap_q ? bswap(out_word) : out_word) : '0;
    assign d_strb_o      = '1;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;
    assign blocks_done_o = blocks_done_q;
    assign state_o       = state_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) state_q <= ST_IDLE;
        else                  state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_i && (nblocks_i != '0)) state_d = ST_GATHER;
            ST_GATHER: if (a_valid_i && last_beat)       state_d = ST_ISSUE;
            ST_ISSUE:  if (blk_ready_i)                  state_d = ST_WAIT;
            ST_WAIT:   if (res_valid_i)                  state_d = ST_DRAIN;
            ST_DRAIN:  if (d_ready_i && last_beat)       state_d = last_block ? ST_IDLE : ST_GATHER;
            default:                                     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            beat_q        <= '0;
            buf_q         <= '0;
            nblocks_q     <= '0;
            blocks_done_q <= '0;
            swap_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        nblocks_q     <= nblocks_i;
                        swap_q        <= swap_i;
                        blocks_done_q <= '0;
                        beat_q        <= '0;
                        // An empty job completes immediately without leaving IDLE.
                        done_q        <= (nblocks_i == '0);
                    end
                end
                ST_GATHER: begin
                    if (a_valid_i) begin
                        for (int i = 0; i < BEATS; i++) begin
                            if (beat_q == BEAT_W'(i)) buf_q[i*DATA_W +: DATA_W] <= in_word;
                        end
                        beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (res_valid_i) buf_q <= res_i;
                end
                ST_DRAIN: begin
                    if (d_ready_i) begin
                        beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);
                        if (last_beat) begin
                            blocks_done_q <= blocks_done_q + CNT_W'(1);
                            done_q        <= last_block;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_block_stream_buffer.sv
// Bench for aes_block_stream_buffer: directed jobs through a loopback/invert core model with a
// queue-based scoreboard, plus 2-beat and 1-beat parametrisations.
module tb_aes_block_stream_buffer;

    localparam int DATA_W  = 32;
    localparam int BLOCK_W = 128;
    localparam int CNT_W   = 16;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rst_i, clear_i;
    initial forever #5 clk_i = ~clk_i;

    // ---------------- main DUT (4 beats per block) ----------------
    logic                start_i, swap_i, a_valid_i, a_ready_o;
    logic [CNT_W-1:0]    nblocks_i, blocks_done_o;
    logic [DATA_W-1:0]   a_data_i, d_data_o;
    logic [BLOCK_W-1:0]  blk_o, res_i;
    logic                blk_valid_o, blk_ready_i, res_valid_i, res_ready_o;
    logic                d_valid_o, d_ready_i, busy_o, done_o;
    logic [DATA_W/8-1:0] d_strb_o;
    logic [2:0]          state_o;
    logic                core_inv;

    assign res_i = core_inv ? ~blk_o : blk_o;

    aes_block_stream_buffer #(.DATA_W(DATA_W), .BLOCK_W(BLOCK_W), .CNT_W(CNT_W)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
        .nblocks_i(nblocks_i), .swap_i(swap_i), .a_data_i(a_data_i), .a_valid_i(a_valid_i),
        .a_ready_o(a_ready_o), .blk_o(blk_o), .blk_valid_o(blk_valid_o), .blk_ready_i(blk_ready_i),
        .res_i(res_i), .res_valid_i(res_valid_i), .res_ready_o(res_ready_o), .d_data_o(d_data_o),
        .d_valid_o(d_valid_o), .d_ready_i(d_ready_i), .d_strb_o(d_strb_o), .busy_o(busy_o),
        .done_o(done_o), .blocks_done_o(blocks_done_o), .state_o(state_o)
    );

    // ---------------- parametrised DUTs (2 beats, 1 beat) ----------------
    logic               p_start, p_one, p64_swap, p128_swap;
    logic [CNT_W-1:0]   p_nblocks;
    logic [63:0]        p64_a_data, p64_d_data;
    logic               p64_a_valid, p64_a_ready, p64_blk_valid, p64_res_ready, p64_d_valid;
    logic               p64_busy, p64_done;
    logic [127:0]       p64_blk;
    logic [7:0]         p64_strb;
    logic [CNT_W-1:0]   p64_bd;
    logic [2:0]         p64_state;
    logic [127:0]       p128_a_data, p128_d_data, p128_blk;
    logic               p128_a_valid, p128_a_ready, p128_blk_valid, p128_res_ready, p128_d_valid;
    logic               p128_busy, p128_done;
    logic [15:0]        p128_strb;
    logic [CNT_W-1:0]   p128_bd;
    logic [2:0]         p128_state;

    aes_block_stream_buffer #(.DATA_W(64), .BLOCK_W(128), .CNT_W(CNT_W)) u_dut64 (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(p_start),
        .nblocks_i(p_nblocks), .swap_i(p64_swap), .a_data_i(p64_a_data), .a_valid_i(p64_a_valid),
        .a_ready_o(p64_a_ready), .blk_o(p64_blk), .blk_valid_o(p64_blk_valid), .blk_ready_i(p_one),
        .res_i(p64_blk), .res_valid_i(p_one), .res_ready_o(p64_res_ready), .d_data_o(p64_d_data),
        .d_valid_o(p64_d_valid), .d_ready_i(p_one), .d_strb_o(p64_strb), .busy_o(p64_busy),
        .done_o(p64_done), .blocks_done_o(p64_bd), .state_o(p64_state)
    );

    aes_block_stream_buffer #(.DATA_W(128), .BLOCK_W(128), .CNT_W(CNT_W)) u_dut128 (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(p_start),
        .nblocks_i(p_nblocks), .swap_i(p128_swap), .a_data_i(p128_a_data), .a_valid_i(p128_a_valid),
        .a_ready_o(p128_a_ready), .blk_o(p128_blk), .blk_valid_o(p128_blk_valid), .blk_ready_i(p_one),
        .res_i(p128_blk), .res_valid_i(p_one), .res_ready_o(p128_res_ready), .d_data_o(p128_d_data),
        .d_valid_o(p128_d_valid), .d_ready_i(p_one), .d_strb_o(p128_strb), .busy_o(p128_busy),
        .done_o(p128_done), .blocks_done_o(p128_bd), .state_o(p128_state)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [DATA_W-1:0]  exp_q[$];
    logic [BLOCK_W-1:0] blk_q[$];
    logic [63:0]        p64_q[$];
    logic [127:0]       p128_q[$];
    int   job_n, bd_model, beats_seen, done_cnt, p64_done_cnt, p128_done_cnt;
    bit   pend_bd, pend_done, first_out_taken;
    logic [127:0] last_blk_seen;
    logic [31:0]  first_out_seen;
    int   blk_delay;
    bit   d_rand, d_hold;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [31:0] word_of(input int b, input int k);
        return {8'(b*16 + k*4 + 3), 8'(b*16 + k*4 + 2), 8'(b*16 + k*4 + 1), 8'(b*16 + k*4)};
    endfunction

    // ---------------- core / sink models ----------------
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        blk_ready_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (blk_valid_o) begin
                if (wait_cnt >= blk_delay) blk_ready_i = 1'b1;
                else begin
                    blk_ready_i = 1'b0;
                    wait_cnt++;
                end
            end else begin
                blk_ready_i = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    initial begin
        d_ready_i = 1'b1;
        forever begin
            @(negedge clk_i);
            d_ready_i = d_hold ? 1'b0 : (d_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // ---------------- monitors ----------------
    initial begin
        forever begin
            @(negedge clk_i);
            #1;
            if (pend_bd) begin
                check("blocks_done_step", 128'(blocks_done_o), 128'(bd_model));
                pend_bd = 1'b0;
            end
            if (pend_done) begin
                check("done_after_last_beat", 128'(done_o), 128'(1));
                pend_done = 1'b0;
            end
            if (done_o) done_cnt++;
            if (blk_valid_o && blk_ready_i) begin
                last_blk_seen = blk_o;
                if (blk_q.size() == 0) check("blk_unexpected", 128'(blk_valid_o), 128'(0));
                else                   check("blk_to_core", blk_o, blk_q.pop_front());
            end
            if (d_valid_o) begin
                if (exp_q.size() == 0) check("d_unexpected", 128'(d_valid_o), 128'(0));
                else if (!d_ready_i)   check("d_stall_hold", 128'(d_data_o), 128'(exp_q[0]));
                else begin
                    if (!first_out_taken) begin
                        first_out_seen  = d_data_o;
                        first_out_taken = 1'b1;
                    end
                    check("d_data", 128'(d_data_o), 128'(exp_q.pop_front()));
                    beats_seen++;
                    if (beats_seen % 4 == 0) begin
                        bd_model++;
                        pend_bd = 1'b1;
                        if (bd_model == job_n) pend_done = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            #1;
            if (p64_done)  p64_done_cnt++;
            if (p128_done) p128_done_cnt++;
            if (p64_d_valid) begin
                if (p64_q.size() == 0) check("p64_unexpected", 128'(p64_d_valid), 128'(0));
                else                   check("p64_data", 128'(p64_d_data), 128'(p64_q.pop_front()));
            end
            if (p128_d_valid) begin
                if (p128_q.size() == 0) check("p128_unexpected", 128'(p128_d_valid), 128'(0));
                else                    check("p128_data", p128_d_data, p128_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        check("watchdog_timeout", 128'(1), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic [31:0] w);
        int t;
        a_data_i  = w;
        a_valid_i = 1'b1;
        t = 0;
        while (!a_ready_o && t < 2000) begin
            @(negedge clk_i);
            t++;
        end
        check("a_ready_timeout", 128'(a_ready_o), 128'(1));
        @(negedge clk_i);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_a_ready"},     128'(a_ready_o),     128'(0));
        check({tag, "_blk_valid"},   128'(blk_valid_o),   128'(0));
        check({tag, "_res_ready"},   128'(res_ready_o),   128'(0));
        check({tag, "_d_valid"},     128'(d_valid_o),     128'(0));
        check({tag, "_d_data"},      128'(d_data_o),      128'(0));
        check({tag, "_busy"},        128'(busy_o),        128'(0));
        check({tag, "_done"},        128'(done_o),        128'(0));
        check({tag, "_blocks_done"}, 128'(blocks_done_o), 128'(0));
        check({tag, "_strb"},        128'(d_strb_o),      128'(4'hF));
        check({tag, "_state"},       128'(state_o),       128'(0));
    endtask

    task automatic run_job(input int nblk, input bit sw, input bit inv, input int dly,
                           input bit bp, input bit poke);
        logic [127:0] blk;
        logic [31:0]  w;
        int t, d0;
        d0 = done_cnt;
        job_n = nblk; bd_model = 0; beats_seen = 0; first_out_taken = 1'b0;
        core_inv = inv; blk_delay = dly; d_rand = bp;
        nblocks_i = CNT_W'(nblk); swap_i = sw; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        if (poke) begin
            nblocks_i = CNT_W'(5); swap_i = ~sw; start_i = 1'b1;
            @(negedge clk_i);
            start_i = 1'b0;
        end
        for (int b = 0; b < nblk; b++) begin
            blk = '0;
            for (int k = 0; k < 4; k++) begin
                w = word_of(b, k);
                blk[k*32 +: 32] = sw ? bswap32(w) : w;
                exp_q.push_back(inv ? ~w : w);
            end
            blk_q.push_back(blk);
            for (int k = 0; k < 4; k++) begin
                if (bp) begin
                    a_valid_i = 1'b0;
                    repeat ($urandom_range(0, 2)) @(negedge clk_i);
                end
                send_beat(word_of(b, k));
            end
        end
        a_valid_i = 1'b0;
        t = 0;
        while (busy_o && t < 3000) begin
            @(negedge clk_i);
            t++;
        end
        check("job_end_timeout", 128'(busy_o), 128'(0));
        repeat (2) @(negedge clk_i);
        check("done_pulse_count",  128'(done_cnt - d0),  128'(1));
        check("blocks_done_final", 128'(blocks_done_o),  128'(nblk));
        check("out_queue_drained", 128'(exp_q.size()),   128'(0));
        check("blk_queue_drained", 128'(blk_q.size()),   128'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t, d0;
        rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; nblocks_i = '0; swap_i = 1'b0;
        a_data_i = '0; a_valid_i = 1'b0; res_valid_i = 1'b1; core_inv = 1'b0;
        blk_delay = 0; d_rand = 1'b0; d_hold = 1'b0;
        p_start = 1'b0; p_one = 1'b1; p_nblocks = '0; p64_swap = 1'b0; p128_swap = 1'b1;
        p64_a_data = '0; p64_a_valid = 1'b0; p128_a_data = '0; p128_a_valid = 1'b0;
        job_n = 0; bd_model = 0; beats_seen = 0; done_cnt = 0; p64_done_cnt = 0; p128_done_cnt = 0;
        pend_bd = 1'b0; pend_done = 1'b0; first_out_taken = 1'b0;
        last_blk_seen = '0; first_out_seen = '0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        check_idle_outputs("reset");

        // single block, start pulse while busy must be ignored
        run_job(1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        check("single_blk", last_blk_seen, 128'h0F0E0D0C_0B0A0908_07060504_03020100);

        // byte swap with loopback, then with an inverting core
        run_job(1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        check("swap_blk_slice0", 128'(last_blk_seen[31:0]), 128'(32'h00010203));
        run_job(1, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        check("swap_inv_beat0", 128'(first_out_seen), 128'(32'hFCFDFEFF));

        // backpressure on every interface
        run_job(3, 1'b0, 1'b0, 5, 1'b1, 1'b0);

        // empty job
        core_inv = 1'b0; blk_delay = 0; d_rand = 1'b0;
        nblocks_i = '0; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        check("nblk0_done",  128'(done_o), 128'(1));
        check("nblk0_busy",  128'(busy_o), 128'(0));
        @(negedge clk_i);
        check("nblk0_done_drop", 128'(done_o), 128'(0));
        check("nblk0_busy_after", 128'(busy_o), 128'(0));

        // clear while the block is offered to a stalled core
        blk_delay = 20;
        nblocks_i = CNT_W'(2); start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int k = 0; k < 4; k++) send_beat(word_of(0, k));
        a_valid_i = 1'b0;
        t = 0;
        while (!blk_valid_o && t < 100) begin
            @(negedge clk_i);
            t++;
        end
        check("issue_reached", 128'(blk_valid_o), 128'(1));
        blk_q.delete();
        d0 = done_cnt;
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        check("clear_blk_valid", 128'(blk_valid_o), 128'(0));
        check("clear_busy",      128'(busy_o),      128'(0));
        repeat (10) @(negedge clk_i);
        check("clear_no_done", 128'(done_cnt - d0), 128'(0));
        blk_delay = 0;

        // reset in the middle of a stalled drain
        d_hold = 1'b1; job_n = 2; bd_model = 0; beats_seen = 0;
        nblocks_i = CNT_W'(2); start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int k = 0; k < 4; k++) exp_q.push_back(word_of(0, k));
        blk_q.push_back({word_of(0, 3), word_of(0, 2), word_of(0, 1), word_of(0, 0)});
        for (int k = 0; k < 4; k++) send_beat(word_of(0, k));
        a_valid_i = 1'b0;
        t = 0;
        while (!d_valid_o && t < 100) begin
            @(negedge clk_i);
            t++;
        end
        check("drain_reached", 128'(d_valid_o), 128'(1));
        d0 = done_cnt;
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        exp_q.delete();
        blk_q.delete();
        d_hold = 1'b0;
        check_idle_outputs("mid_drain_reset");
        repeat (3) @(negedge clk_i);
        check("reset_no_done", 128'(done_cnt - d0), 128'(0));

        // 2-beat and 1-beat blocks, four blocks each, loopback core
        p_nblocks = CNT_W'(4); p_start = 1'b1;
        @(negedge clk_i);
        p_start = 1'b0;
        fork
            begin
                logic [63:0] w64;
                int tt;
                p64_a_valid = 1'b1;
                for (int b = 0; b < 4; b++) begin
                    for (int k = 0; k < 2; k++) begin
                        w64 = {16'hBEEF, 8'(b), 8'(k), 32'h0102_0304};
                        p64_a_data = w64;
                        p64_q.push_back(w64);
                        tt = 0;
                        while (!p64_a_ready && tt < 500) begin
                            @(negedge clk_i);
                            tt++;
                        end
                        @(negedge clk_i);
                    end
                end
                p64_a_valid = 1'b0;
            end
            begin
                logic [127:0] w128;
                int tt;
                p128_a_valid = 1'b1;
                for (int b = 0; b < 4; b++) begin
                    w128 = {32'hDEAD_BEEF, 32'(b), 32'h0A0B_0C0D, 32'h1111_2222};
                    p128_a_data = w128;
                    p128_q.push_back(w128);
                    tt = 0;
                    while (!p128_a_ready && tt < 500) begin
                        @(negedge clk_i);
                        tt++;
                    end
                    @(negedge clk_i);
                end
                p128_a_valid = 1'b0;
            end
        join
        t = 0;
        while ((p64_busy || p128_busy) && t < 1000) begin
            @(negedge clk_i);
            t++;
        end
        repeat (2) @(negedge clk_i);
        check("p64_blocks_done",  128'(p64_bd),        128'(4));
        check("p128_blocks_done", 128'(p128_bd),       128'(4));
        check("p64_done_count",   128'(p64_done_cnt),  128'(1));
        check("p128_done_count",  128'(p128_done_cnt), 128'(1));
        check("p64_queue_drained",  128'(p64_q.size()),  128'(0));
        check("p128_queue_drained", 128'(p128_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aes_block_stream_buffer.md
Name: aes_block_stream_buffer

Overview:
- Parametrised successor of the single-block AES data mover in the HWPE engine.
- Gathers BLOCK_W/DATA_W input stream beats into one block buffer and hands the block to the cipher core over a valid/ready port.
- Captures the core's result block into the same buffer and serialises it onto the output stream.
- Runs a job of NUM_BLOCKS blocks per start, with optional per-beat byte swap; sits between the streamer and the AES core.

Parameters:
- DATA_W, 32, stream beat width in bits; multiple of 8.
- BLOCK_W, 128, block width in bits; integer multiple of DATA_W.
- CNT_W, 16, width of block count and flag counters.
- Derived, not overridable: BEATS = BLOCK_W/DATA_W; BEAT_W = max(1, clog2(BEATS)).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- clear_i  in  1  synchronous soft clear; same effect as rst_i.
- start_i  in  1  job start pulse; honoured only in IDLE.
- nblocks_i  in  CNT_W  blocks in job; sampled with start_i.
- swap_i  in  1  byte-reverse each beat in and out; sampled with start_i.
- a_data_i  in  DATA_W  input stream data.
- a_valid_i  in  1  input stream valid.
- a_ready_o  out  1  input stream ready.
- blk_o  out  BLOCK_W  block to core.
- blk_valid_o  out  1  block valid.
- blk_ready_i  in  1  core accepts block.
- res_i  in  BLOCK_W  result block from core.
- res_valid_i  in  1  result valid.
- res_ready_o  out  1  buffer accepts result.
- d_data_o  out  DATA_W  output stream data.
- d_valid_o  out  1  output stream valid.
- d_ready_i  in  1  output stream ready.
- d_strb_o  out  DATA_W/8  output byte strobe; constant all ones.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse at job end.
- blocks_done_o  out  CNT_W  blocks fully drained in current job.

Behaviour:
Reset and clear
- On rst_i or clear_i: state IDLE; buffer, beat counter, block counters, latched swap = 0.
- All outputs 0 except d_strb_o (all ones).
- clear_i has priority over every other event, including mid-job; in-flight data is dropped with no done_o.

FSM states: IDLE, GATHER, ISSUE, WAIT, DRAIN.
- IDLE: on start_i, latch nblocks_i and swap_i, clear blocks_done_o.
  - nblocks_i == 0: stay IDLE, assert done_o next cycle.
  - Otherwise go to GATHER with beat = 0.
- GATHER: a_ready_o = 1.
  - Each a_valid_i & a_ready_o writes the beat (byte-reversed if swap) into slice [beat*DATA_W +: DATA_W]; beat 0 is the LSB.
  - On the beat BEATS-1: beat resets to 0, go to ISSUE.
- ISSUE: blk_valid_o = 1, blk_o = buffer held stable. On blk_ready_i go to WAIT.
- WAIT: res_ready_o = 1. On res_valid_i capture res_i into buffer, go to DRAIN.
- DRAIN: d_valid_o = 1, d_data_o = slice[beat] (byte-reversed if swap). Data is held stable while d_ready_i = 0.
  - On d_ready_i, beat increments.
  - On the last beat, blocks_done_o increments.
  - If blocks_done+1 == nblocks: go to IDLE and pulse done_o on the same transition edge, i.e. done_o is high the cycle after the last output handshake.
  - Otherwise go to GATHER.

Handshake and timing
- All handshake outputs decode registered state only; there is no combinational path from any valid to any ready.
- Minimum per-block latency from first input beat to first output beat: BEATS + 2 cycles with an always-ready core.
- There is no overlap between gather of block n+1 and drain of block n; single buffer.
- start_i outside IDLE is ignored.
- a_valid_i outside GATHER is not consumed.
- res_valid_i outside WAIT is ignored.
- blocks_done_o holds its final value in IDLE until the next start_i.
- BEATS == 1 degenerates correctly: one beat per block, beat counter constant 0.

Test Plan:
- Reset/clear: assert rst_i for 2 cycles mid-DRAIN, then release -> state IDLE; a_ready_o, d_valid_o, blk_valid_o, busy_o, done_o all 0; blocks_done_o = 0; d_strb_o = 4'hF.
- Single block: start_i with nblocks=1, swap=0; input 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C; core loops blk_o back as res_i -> blk_o = 128'h0F0E0D0C_0B0A0908_07060504_03020100; output beats are the same four words in order; done_o pulses once; blocks_done_o = 1.
- Byte swap: same input with swap=1 and loopback core -> output words equal the input words, blk_o slice0 = 32'h00010203; run again with a core that XORs all ones -> out beat 0 = 32'hFCFDFEFF.
- Backpressure: nblocks=3, random a_valid_i gaps, blk_ready_i delayed 5 cycles, d_ready_i toggled at 50% -> no beat lost or duplicated; d_data_o stable while stalled; blocks_done_o steps 1, 2, 3; a single done_o pulse.
- Boundaries: nblocks=0 -> done_o on the cycle after start_i, busy_o never set; start_i while busy is ignored; clear_i during ISSUE -> blk_valid_o drops the next cycle and no done_o follows.
- Parametrisation: DATA_W=64, BLOCK_W=128 and DATA_W=128, BLOCK_W=128 -> 2-beat and 1-beat blocks round-trip bit-exact through a loopback core over 4 blocks.
